// File: rtl/scene_read_arbiter_if.sv
// scene_read_arbiter_if
//   Request/response bundle between the ray-pipeline requesters and the
//   scene-memory read arbiter.
//   Signals:
//     req_valid    requester -> arbiter  request pending, held until gnt
//     req_is_light requester -> arbiter  1 = light read, 0 = geometry read
//     req_addr     requester -> arbiter  packed addresses, i at [i*ADDR_W +: ADDR_W]
//     gnt          arbiter -> requester  one-cycle one-hot grant
//     resp_valid   arbiter -> requester  one-cycle one-hot response strobe
//     resp_light   arbiter -> requester  light data (light reads)
//     resp_geo     arbiter -> requester  geometry data (geometry reads)
//     resp_stale   arbiter -> requester  mem_ready dropped while the read was in flight
//   Modports: master = requester side, slave = arbiter side.
interface scene_read_arbiter_if #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 8,
  parameter int LIGHT_W        = 16,
  parameter int GEOMETRY_WIDTH = 24
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_is_light;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [LIGHT_W-1:0]        resp_light;
  logic [GEOMETRY_WIDTH-1:0] resp_geo;
  logic                      resp_stale;

  modport master (
    output req_valid, req_is_light, req_addr,
    input  gnt, resp_valid, resp_light, resp_geo, resp_stale
  );

  modport slave (
    input  req_valid, req_is_light, req_addr,
    output gnt, resp_valid, resp_light, resp_geo, resp_stale
  );
endinterface

// File: rtl/scene_read_arbiter.sv
// scene_read_arbiter
//   Shares the scene-memory light/geometry read ports between NUM_REQ
//   ray-pipeline requesters, one read in flight at a time. Arbitration is
//   round-robin; no read is issued until mem_ready. controller_busy tells the
//   processor to hold scene-update instructions while reads are pending.
//   Build option: define SCENE_ARB_FIXED_PRIO_EN for fixed priority (lowest
//   index wins, no round-robin pointer); undefined gives round-robin.
//   Ports:
//     clk_100mhz          in   system clock
//     rst_n               in   asynchronous active-low reset
//     mem_ready           in   scene memory initialised
//     bus                 slave modport of scene_read_arbiter_if (requesters)
//     cur_light           in   light read data, READ_LATENCY cycles after address
//     cur_geo             in   geometry read data, READ_LATENCY cycles after address
//     light_read_addr     out  light read address to the processor
//     geometry_read_addr  out  geometry read address to the processor
//     controller_busy     out  read pending or in flight
module scene_read_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int READ_LATENCY   = 2,
  parameter int ADDR_W         = 8,
  parameter int LIGHT_ADDR_W   = 4,
  parameter int GEO_ADDR_W     = 6,
  parameter int LIGHT_W        = 16,
  parameter int GEOMETRY_WIDTH = 24
) (
  input  logic                      clk_100mhz,
  input  logic                      rst_n,
  input  logic                      mem_ready,
  scene_read_arbiter_if.slave       bus,
  input  logic [LIGHT_W-1:0]        cur_light,
  input  logic [GEOMETRY_WIDTH-1:0] cur_geo,
  output logic [LIGHT_ADDR_W-1:0]   light_read_addr,
  output logic [GEO_ADDR_W-1:0]     geometry_read_addr,
  output logic                      controller_busy
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(READ_LATENCY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                    state_r, state_s;
  logic [IDX_W-1:0]          win_r, win_s;
  logic                      kind_r, kind_s;
  logic [CNT_W-1:0]          cnt_r, cnt_s;
  logic                      stale_r, stale_s;
  logic [NUM_REQ-1:0]        gnt_r, gnt_s;
  logic [NUM_REQ-1:0]        resp_valid_r, resp_valid_s;
  logic                      resp_stale_r, resp_stale_s;
  logic [LIGHT_W-1:0]        resp_light_r, resp_light_s;
  logic [GEOMETRY_WIDTH-1:0] resp_geo_r, resp_geo_s;
  logic [LIGHT_ADDR_W-1:0]   light_addr_r, light_addr_s;
  logic [GEO_ADDR_W-1:0]     geo_addr_r, geo_addr_s;

  logic                      found_s;
  logic [IDX_W-1:0]          pick_s;
  logic [IDX_W-1:0]          cand_s;
  logic [ADDR_W-1:0]         addr_arr_s [NUM_REQ];
  logic [ADDR_W-1:0]         sel_addr_s;
  logic                      unused_addr_s;

`ifndef SCENE_ARB_FIXED_PRIO_EN
  localparam logic [IDX_W:0] NUM_REQ_V = (IDX_W + 1)'(NUM_REQ);
  logic [IDX_W-1:0]          rr_ptr_r, rr_ptr_s;
  logic [IDX_W:0]            sum_s;
`endif

  // Unpack the requester address bus into one word per requester.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
    assign addr_arr_s[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
  end

  assign sel_addr_s = addr_arr_s[pick_s];
  // Only the low bits of the selected address reach the memory ports.
  assign unused_addr_s = ^sel_addr_s;

  // Winner search: first valid requester starting at the round-robin pointer.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    cand_s  = '0;
`ifndef SCENE_ARB_FIXED_PRIO_EN
    sum_s   = '0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef SCENE_ARB_FIXED_PRIO_EN
      cand_s = IDX_W'(k);
`else
      sum_s  = {1'b0, rr_ptr_r} + (IDX_W + 1)'(k);
      cand_s = (sum_s >= NUM_REQ_V) ? IDX_W'(sum_s - NUM_REQ_V) : sum_s[IDX_W-1:0];
`endif
      if (!found_s && bus.req_valid[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state and next-output logic for the read FSM.
  always_comb begin
    state_s      = state_r;
    win_s        = win_r;
    kind_s       = kind_r;
    cnt_s        = cnt_r;
    stale_s      = stale_r;
    gnt_s        = '0;
    resp_valid_s = '0;
    resp_stale_s = 1'b0;
    resp_light_s = resp_light_r;
    resp_geo_s   = resp_geo_r;
    light_addr_s = light_addr_r;
    geo_addr_s   = geo_addr_r;
`ifndef SCENE_ARB_FIXED_PRIO_EN
    rr_ptr_s     = rr_ptr_r;
`endif
    case (state_r)
      IDLE: begin
        if (mem_ready && found_s) begin
          state_s        = ISSUE;
          win_s          = pick_s;
          kind_s         = bus.req_is_light[pick_s];
          stale_s        = 1'b0;
          gnt_s[pick_s]  = 1'b1;
          // Only the requested kind's address moves; the other port keeps its value.
          if (bus.req_is_light[pick_s]) begin
            light_addr_s = sel_addr_s[LIGHT_ADDR_W-1:0];
          end else begin
            geo_addr_s   = sel_addr_s[GEO_ADDR_W-1:0];
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        state_s = WAIT;
        cnt_s   = CNT_W'(READ_LATENCY);
        stale_s = stale_r | ~mem_ready;
      end
      WAIT: begin
        cnt_s = cnt_r - CNT_W'(1);
        // Counter hits zero on this edge: data is valid now.
        if (cnt_r == CNT_W'(1)) begin
          state_s             = RESP;
          resp_valid_s[win_r] = 1'b1;
          resp_stale_s        = stale_r | ~mem_ready;
          stale_s             = 1'b0;
          if (kind_r) begin
            resp_light_s = cur_light;
          end else begin
            resp_geo_s   = cur_geo;
          end
        end else begin
          stale_s = stale_r | ~mem_ready;
        end
      end
      RESP: begin
        state_s = IDLE;
`ifndef SCENE_ARB_FIXED_PRIO_EN
        // The requester just served goes to the back of the line.
        rr_ptr_s = (win_r == LAST_IDX) ? '0 : win_r + IDX_W'(1);
`endif
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      win_r        <= '0;
      kind_r       <= 1'b0;
      cnt_r        <= '0;
      stale_r      <= 1'b0;
      gnt_r        <= '0;
      resp_valid_r <= '0;
      resp_stale_r <= 1'b0;
      resp_light_r <= '0;
      resp_geo_r   <= '0;
      light_addr_r <= '0;
      geo_addr_r   <= '0;
`ifndef SCENE_ARB_FIXED_PRIO_EN
      rr_ptr_r     <= '0;
`endif
    end else begin
      state_r      <= state_s;
      win_r        <= win_s;
      kind_r       <= kind_s;
      cnt_r        <= cnt_s;
      stale_r      <= stale_s;
      gnt_r        <= gnt_s;
      resp_valid_r <= resp_valid_s;
      resp_stale_r <= resp_stale_s;
      resp_light_r <= resp_light_s;
      resp_geo_r   <= resp_geo_s;
      light_addr_r <= light_addr_s;
      geo_addr_r   <= geo_addr_s;
`ifndef SCENE_ARB_FIXED_PRIO_EN
      rr_ptr_r     <= rr_ptr_s;
`endif
    end
  end

  assign bus.gnt            = gnt_r;
  assign bus.resp_valid     = resp_valid_r;
  assign bus.resp_stale     = resp_stale_r;
  assign bus.resp_light     = resp_light_r;
  assign bus.resp_geo       = resp_geo_r;
  assign light_read_addr    = light_addr_r;
  assign geometry_read_addr = geo_addr_r;
  // Busy as soon as anyone asks, so the processor never races a pending read.
  assign controller_busy    = (state_r != IDLE) | (|bus.req_valid);
endmodule

// File: tb/tb_scene_read_arbiter.sv
// tb_scene_read_arbiter
//   Directed bench for scene_read_arbiter: a vector table of single reads
//   plus hand-written sequences for reset, mem_ready gating, round-robin
//   order, stale responses and reset mid-transaction.
module tb_scene_read_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 8;
  localparam int LIGHT_W = 16;
  localparam int GEO_W   = 24;

  logic              clk_100mhz = 1'b0;
  logic              rst_n      = 1'b0;
  logic              mem_ready  = 1'b0;
  logic [LIGHT_W-1:0] cur_light = '0;
  logic [LIGHT_W-1:0] l_pipe    = '0;
  logic [GEO_W-1:0]   cur_geo   = '0;
  logic [GEO_W-1:0]   g_pipe    = '0;
  logic [3:0]         light_read_addr;
  logic [5:0]         geometry_read_addr;
  logic               controller_busy;

  int n_cmp = 0;
  int n_err = 0;

  scene_read_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W),
                          .LIGHT_W(LIGHT_W), .GEOMETRY_WIDTH(GEO_W)) bus ();

  scene_read_arbiter #(.NUM_REQ(NUM_REQ), .READ_LATENCY(2), .ADDR_W(ADDR_W),
                       .LIGHT_ADDR_W(4), .GEO_ADDR_W(6),
                       .LIGHT_W(LIGHT_W), .GEOMETRY_WIDTH(GEO_W)) dut (
    .clk_100mhz         (clk_100mhz),
    .rst_n              (rst_n),
    .mem_ready          (mem_ready),
    .bus                (bus),
    .cur_light          (cur_light),
    .cur_geo            (cur_geo),
    .light_read_addr    (light_read_addr),
    .geometry_read_addr (geometry_read_addr),
    .controller_busy    (controller_busy)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  // Scene memory model: data pattern derived from address, two-cycle latency.
  always @(posedge clk_100mhz) begin
    l_pipe    <= {12'h00A, light_read_addr};
    cur_light <= l_pipe;
    g_pipe    <= {8'hC3, 10'h000, geometry_read_addr};
    cur_geo   <= g_pipe;
  end

  typedef struct {
    int          req;
    logic        is_light;
    logic [7:0]  addr;
    logic [3:0]  exp_gnt;
    logic [3:0]  exp_la;
    logic [5:0]  exp_ga;
    logic [15:0] exp_rl;
    logic [23:0] exp_rg;
  } vec_t;

  vec_t       vecs [5];
  logic [3:0] rr_exp [6];

  task automatic step();
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req_v);
    end
  endtask

  task automatic set_req(input int idx, input logic il, input logic [7:0] a);
    bus.req_valid               = '0;
    bus.req_valid[idx]          = 1'b1;
    bus.req_is_light[idx]       = il;
    bus.req_addr[idx*8 +: 8]    = a;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int got;

    vecs[0] = '{0, 1'b1, 8'h03, 4'b0001, 4'h3, 6'h00, 16'h00A3, 24'h000000};
    vecs[1] = '{2, 1'b1, 8'h05, 4'b0100, 4'h5, 6'h00, 16'h00A5, 24'h000000};
    vecs[2] = '{1, 1'b0, 8'h2A, 4'b0010, 4'h5, 6'h2A, 16'h00A5, 24'hC3002A};
    vecs[3] = '{1, 1'b1, 8'hF7, 4'b0010, 4'h7, 6'h2A, 16'h00A7, 24'hC3002A};
    vecs[4] = '{3, 1'b0, 8'hFF, 4'b1000, 4'h7, 6'h3F, 16'h00A7, 24'hC3003F};
`ifdef SCENE_ARB_FIXED_PRIO_EN
    rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
`endif

    // Reset with random inputs.
    bus.req_valid    = 4'($urandom);
    bus.req_is_light = 4'($urandom);
    bus.req_addr     = $urandom;
    mem_ready        = 1'($urandom);
    step(); step(); step();
    check("rst gnt", bus.gnt, 4'b0);
    check("rst resp_valid", bus.resp_valid, 4'b0);
    check("rst resp_light", bus.resp_light, 16'h0);
    check("rst resp_geo", bus.resp_geo, 24'h0);
    check("rst resp_stale", bus.resp_stale, 1'b0);
    check("rst light_addr", light_read_addr, 4'h0);
    check("rst geo_addr", geometry_read_addr, 6'h0);
    check("rst busy", controller_busy, |bus.req_valid);
    bus.req_valid = '0;
    bus.req_is_light = '0;
    bus.req_addr = '0;
    mem_ready = 1'b1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("idle busy", controller_busy, 1'b0);
      check("idle gnt", bus.gnt, 4'b0);
    end

    // Table of single reads.
    for (int i = 0; i < 5; i++) begin
      set_req(vecs[i].req, vecs[i].is_light, vecs[i].addr);
      step();
      check($sformatf("v%0d gnt", i), bus.gnt, vecs[i].exp_gnt);
      check($sformatf("v%0d light_addr", i), light_read_addr, vecs[i].exp_la);
      check($sformatf("v%0d geo_addr", i), geometry_read_addr, vecs[i].exp_ga);
      bus.req_valid = '0;
      step();
      check($sformatf("v%0d wait resp_valid", i), bus.resp_valid, 4'b0);
      check($sformatf("v%0d wait light_addr", i), light_read_addr, vecs[i].exp_la);
      step(); step();
      check($sformatf("v%0d resp_valid", i), bus.resp_valid, vecs[i].exp_gnt);
      check($sformatf("v%0d resp_light", i), bus.resp_light, vecs[i].exp_rl);
      check($sformatf("v%0d resp_geo", i), bus.resp_geo, vecs[i].exp_rg);
      check($sformatf("v%0d resp_stale", i), bus.resp_stale, 1'b0);
      check($sformatf("v%0d resp gnt", i), bus.gnt, 4'b0);
      step();
      check($sformatf("v%0d post resp_valid", i), bus.resp_valid, 4'b0);
    end

    // All four requesters held valid.
    bus.req_valid    = 4'hF;
    bus.req_is_light = 4'hF;
    bus.req_addr     = 32'h04030201;
    for (int g = 0; g < 6; g++) begin
      got = 0;
      for (int c = 0; c < 12 && got == 0; c++) begin
        step();
        if (bus.gnt != 4'b0) got = 1;
      end
      check($sformatf("rr%0d gnt seen", g), got, 1);
      check($sformatf("rr%0d gnt", g), bus.gnt, rr_exp[g]);
      if (g == 5) bus.req_valid = '0;
    end
    for (int c = 0; c < 6; c++) step();

    // mem_ready low for one cycle during WAIT of a geometry read from req 3.
    set_req(3, 1'b0, 8'h11);
    step();
    check("stale gnt", bus.gnt, 4'b1000);
    bus.req_valid = '0;
    step();
    mem_ready = 1'b0;
    step();
    mem_ready = 1'b1;
    step();
    check("stale resp_valid", bus.resp_valid, 4'b1000);
    check("stale flag", bus.resp_stale, 1'b1);
    check("stale resp_geo", bus.resp_geo, 24'hC30011);
    step();
    check("stale cleared", bus.resp_stale, 1'b0);
    set_req(0, 1'b1, 8'h02);
    step();
    check("fresh gnt", bus.gnt, 4'b0001);
    bus.req_valid = '0;
    step(); step(); step();
    check("fresh resp_valid", bus.resp_valid, 4'b0001);
    check("fresh stale", bus.resp_stale, 1'b0);
    check("fresh resp_light", bus.resp_light, 16'h00A2);
    step();

    // mem_ready low blocks issue.
    mem_ready = 1'b0;
    set_req(0, 1'b0, 8'h04);
    for (int c = 0; c < 20; c++) begin
      step();
      check("mr0 gnt", bus.gnt, 4'b0);
      check("mr0 busy", controller_busy, 1'b1);
    end
    mem_ready = 1'b1;
    step();
    check("mr1 gnt", bus.gnt, 4'b0001);
    bus.req_valid = '0;
    step(); step(); step();
    check("mr1 resp_valid", bus.resp_valid, 4'b0001);
    check("mr1 resp_geo", bus.resp_geo, 24'hC30004);
    step();

    // Reset one cycle after grant aborts the read.
    set_req(2, 1'b1, 8'h09);
    step();
    check("abort gnt", bus.gnt, 4'b0100);
    step();
    rst_n = 1'b0;
    #1;
    check("abort rst gnt", bus.gnt, 4'b0);
    check("abort rst light_addr", light_read_addr, 4'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("abort no resp", bus.resp_valid, 4'b0);
      check("abort no gnt", bus.gnt, 4'b0);
    end
    rst_n = 1'b1;
    step();
    check("regrant gnt", bus.gnt, 4'b0100);
    bus.req_valid = '0;
    step();
    check("regrant early resp", bus.resp_valid, 4'b0);
    step(); step();
    check("regrant resp_valid", bus.resp_valid, 4'b0100);
    check("regrant resp_light", bus.resp_light, 16'h00A9);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
